f_ctrl: RTL and testbench

Sequencer for the BLAKE2 compression function F. Accepts one block-compression request, then walks the working-vector datapath through INIT, ROUNDS×8 G-steps (each split into two half-steps) and the final h-update. Drives `sub_ctr`/`rnd_ctr` straight into `f_sched`, plus the enable strobes for the G datapath. Signals completion with a valid/ack handshake.

---
 rtl/bloke2_pkg.sv | 27 ++
 rtl/f_step_ctr.sv | 53 +++++
 rtl/f_ctrl.sv | 141 ++++++++++++++
 tb/tb_f_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bloke2_pkg.sv
// Shared types and sizing for the BLAKE2 compression-function sequencer
// and the message/state schedule (f_sched) it drives.
package bloke2_pkg;

  // Top-level sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } f_state_e;

  localparam int ROUNDS_MAX   = 12;
  localparam int G_PER_ROUND  = 8;
  localparam int HALVES_PER_G = 2;

  // Counter widths shared with f_sched
  localparam int SUB_W = 3;
  localparam int RND_W = 4;

  // Number of ROUND cycles a full compression spends in the G datapath
  function automatic int round_cycles(input int rounds);
    return rounds * G_PER_ROUND * HALVES_PER_G;
  endfunction

endpackage

// File: rtl/f_step_ctr.sv
// Half/sub/round counter chain for the G-step walk. Counters advance only
// while en is high; clr returns them to zero and has priority over en.
module f_step_ctr
  import bloke2_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic             g_half,
  output logic [SUB_W-1:0] sub_ctr,
  output logic [RND_W-1:0] rnd_ctr,
  output logic             last
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(G_PER_ROUND - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  logic             half_r;
  logic [SUB_W-1:0] sub_r;
  logic [RND_W-1:0] rnd_r;

  // Step half -> sub -> rnd; rnd wraps at the last round so it can never reach ROUNDS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_r <= 1'b0;
      sub_r  <= {SUB_W{1'b0}};
      rnd_r  <= {RND_W{1'b0}};
    end else if (clr) begin
      half_r <= 1'b0;
      sub_r  <= {SUB_W{1'b0}};
      rnd_r  <= {RND_W{1'b0}};
    end else if (en) begin
      half_r <= ~half_r;
      if (half_r) begin
        if (sub_r == SUB_LAST) begin
          sub_r <= {SUB_W{1'b0}};
          rnd_r <= (rnd_r == RND_LAST) ? {RND_W{1'b0}} : rnd_r + RND_W'(1);
        end else begin
          sub_r <= sub_r + SUB_W'(1);
        end
      end
    end
  end

  assign g_half  = half_r;
  assign sub_ctr = sub_r;
  assign rnd_ctr = rnd_r;
  assign last    = half_r && (sub_r == SUB_LAST) && (rnd_r == RND_LAST);

endmodule

// File: rtl/f_ctrl.sv
// Sequencer for the BLAKE2 compression function F: INIT, ROUNDS x 8 G-steps
// (two half-steps each), final h-update, then a done/ack handshake.
// All outputs come straight from flops.
module f_ctrl
  import bloke2_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             last_blk,
  input  logic             abort,
  output logic             start_ready,
  output logic             busy,
  output logic             f_flag,
  output logic             init_v,
  output logic             g_en,
  output logic             g_half,
  output logic [SUB_W-1:0] sub_ctr,
  output logic [RND_W-1:0] rnd_ctr,
  output logic             fin_en,
  output logic             done,
  input  logic             done_ack
);

  f_state_e state_r;
  f_state_e state_nxt_s;
  logic     f_flag_r;
  logic     f_flag_nxt_s;
  logic     start_ready_r;
  logic     busy_r;
  logic     init_v_r;
  logic     g_en_r;
  logic     fin_en_r;
  logic     done_r;

  logic     ctr_clr_s;
  logic     ctr_en_s;
  logic     ctr_last_s;
  logic     abort_hit_s;

  // abort only matters once a request is in flight
  assign abort_hit_s = abort && (state_r != ST_IDLE);

  // Counters run only in ROUND; they clear on leaving ROUND so f_sched never sees stale selects
  assign ctr_en_s  = (state_r == ST_ROUND) && !abort_hit_s;
  assign ctr_clr_s = (state_r != ST_ROUND) || abort_hit_s || ctr_last_s;

  f_step_ctr #(
    .ROUNDS (ROUNDS)
  ) u_step_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr_s),
    .en      (ctr_en_s),
    .g_half  (g_half),
    .sub_ctr (sub_ctr),
    .rnd_ctr (rnd_ctr),
    .last    (ctr_last_s)
  );

  // Next-state and finalization-flag logic; abort overrides every advance
  always_comb begin
    state_nxt_s  = state_r;
    f_flag_nxt_s = f_flag_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s  = ST_INIT;
          f_flag_nxt_s = last_blk;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        state_nxt_s = ST_ROUND;
      end
      ST_ROUND: begin
        if (ctr_last_s) begin
          state_nxt_s = ST_FINAL;
        end else begin
          state_nxt_s = ST_ROUND;
        end
      end
      ST_FINAL: begin
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        if (done_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        f_flag_nxt_s = 1'b0;
      end
    endcase
    if (abort_hit_s) begin
      state_nxt_s  = ST_IDLE;
      f_flag_nxt_s = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register plus output flops decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      f_flag_r      <= 1'b0;
      start_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      init_v_r      <= 1'b0;
      g_en_r        <= 1'b0;
      fin_en_r      <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      f_flag_r      <= f_flag_nxt_s;
      start_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r        <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_ROUND) ||
                       (state_nxt_s == ST_FINAL);
      init_v_r      <= (state_nxt_s == ST_INIT);
      g_en_r        <= (state_nxt_s == ST_ROUND);
      fin_en_r      <= (state_nxt_s == ST_FINAL);
      done_r        <= (state_nxt_s == ST_DONE);
    end
  end

  assign start_ready = start_ready_r;
  assign busy        = busy_r;
  assign f_flag      = f_flag_r;
  assign init_v      = init_v_r;
  assign g_en        = g_en_r;
  assign fin_en      = fin_en_r;
  assign done        = done_r;

endmodule

// File: tb/tb_f_ctrl.sv
// Bench for f_ctrl: a ROUNDS=12 and a ROUNDS=10 instance, each compared every
// cycle against a cycle-count model, plus directed literal expectations.
module tb_f_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start_v = 2'b00;
  logic [1:0] last_v = 2'b00;
  logic [1:0] abort_v = 2'b00;
  logic [1:0] ack_v = 2'b00;

  logic       sr_a, busy_a, ff_a, iv_a, ge_a, gh_a, fe_a, dn_a;
  logic [2:0] sub_a;
  logic [3:0] rnd_a;
  logic       sr_b, busy_b, ff_b, iv_b, ge_b, gh_b, fe_b, dn_b;
  logic [2:0] sub_b;
  logic [3:0] rnd_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  f_ctrl #(.ROUNDS(12)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .last_blk(last_v[0]),
    .abort(abort_v[0]), .start_ready(sr_a), .busy(busy_a), .f_flag(ff_a),
    .init_v(iv_a), .g_en(ge_a), .g_half(gh_a), .sub_ctr(sub_a), .rnd_ctr(rnd_a),
    .fin_en(fe_a), .done(dn_a), .done_ack(ack_v[0])
  );

  f_ctrl #(.ROUNDS(10)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .last_blk(last_v[1]),
    .abort(abort_v[1]), .start_ready(sr_b), .busy(busy_b), .f_flag(ff_b),
    .init_v(iv_b), .g_en(ge_b), .g_half(gh_b), .sub_ctr(sub_b), .rnd_ctr(rnd_b),
    .fin_en(fe_b), .done(dn_b), .done_ack(ack_v[1])
  );

  // Observed outputs: {start_ready,busy,f_flag,init_v,g_en,g_half,sub[2:0],rnd[3:0],fin_en,done}
  logic [14:0] obs_a, obs_b;
  assign obs_a = {sr_a, busy_a, ff_a, iv_a, ge_a, gh_a, sub_a, rnd_a, fe_a, dn_a};
  assign obs_b = {sr_b, busy_b, ff_b, iv_b, ge_b, gh_b, sub_b, rnd_b, fe_b, dn_b};

  // Model: ph 0 idle, 1 busy (k = edges since accept), 2 done
  typedef struct packed {
    logic [1:0]  ph;
    logic [15:0] k;
    logic        flg;
  } mst_t;

  mst_t m_a = '0;
  mst_t m_b = '0;

  function automatic mst_t step(input mst_t s, input int r, input logic st,
                                input logic lb, input logic ab, input logic ak);
    mst_t ns;
    ns = s;
    if (s.ph == 2'd0) begin
      if (st) begin
        ns.ph = 2'd1; ns.k = 16'd0; ns.flg = lb;
      end
    end else if (ab) begin
      ns.ph = 2'd0; ns.flg = 1'b0;
    end else if (s.ph == 2'd1) begin
      if (int'(s.k) == 16 * r + 1) ns.ph = 2'd2;
      else ns.k = s.k + 16'd1;
    end else if (ak) begin
      ns.ph = 2'd0;
    end
    return ns;
  endfunction

  function automatic logic [14:0] exp_out(input mst_t s, input int r);
    logic [14:0] o;
    int idx;
    o = '0;
    o[14] = (s.ph == 2'd0);
    o[13] = (s.ph == 2'd1);
    o[12] = s.flg;
    o[0]  = (s.ph == 2'd2);
    if (s.ph == 2'd1) begin
      if (s.k == 16'd0) begin
        o[11] = 1'b1;
      end else if (int'(s.k) <= 16 * r) begin
        idx    = int'(s.k) - 1;
        o[10]  = 1'b1;
        o[9]   = 1'(idx % 2);
        o[8:6] = 3'((idx / 2) % 8);
        o[5:2] = 4'(idx / 16);
      end else begin
        o[1] = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model update on the same edges the DUT sees
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_a = '0;
        m_b = '0;
      end else begin
        m_a = step(m_a, 12, start_v[0], last_v[0], abort_v[0], ack_v[0]);
        m_b = step(m_b, 10, start_v[1], last_v[1], abort_v[1], ack_v[1]);
      end
    end
  end

  // Cycle-by-cycle compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("model_a", 32'(obs_a), 32'(exp_out(m_a, 12)));
      chk("model_b", 32'(obs_b), 32'(exp_out(m_b, 10)));
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    int done_j_a, done_j_b, g_a, g_b, fin_a, max_rnd_b;

    // Reset
    repeat (3) tick();
    chk("reset_a", 32'(obs_a), 32'h4000);
    chk("reset_b", 32'(obs_b), 32'h4000);
    rst_n = 1'b1;
    tick();

    // Single request on both instances, last_blk = 1
    start_v = 2'b11; last_v = 2'b11;
    tick();
    start_v = 2'b00; last_v = 2'b00;
    chk("init_v_a", 32'(iv_a), 32'd1);
    chk("f_flag_a", 32'(ff_a), 32'd1);
    done_j_a = -1; done_j_b = -1; g_a = 0; g_b = 0; fin_a = 0; max_rnd_b = 0;
    for (int j = 1; j <= 210; j++) begin
      start_v[0] = (j > 195 && j < 205) ? 1'(j % 2) : 1'b0;
      tick();
      if (ge_a) g_a++;
      if (ge_b) begin
        g_b++;
        if (int'(rnd_b) > max_rnd_b) max_rnd_b = int'(rnd_b);
      end
      if (fe_a) fin_a++;
      if (dn_a && done_j_a < 0) done_j_a = j;
      if (dn_b && done_j_b < 0) done_j_b = j;
      if (j == 16) chk("wrap_pre", 32'({sub_a, rnd_a, gh_a}), 32'({3'd7, 4'd0, 1'b1}));
      if (j == 17) chk("wrap_post", 32'({sub_a, rnd_a, gh_a}), 32'({3'd0, 4'd1, 1'b0}));
    end
    start_v = 2'b00;
    chk("done_lat_a", 32'(done_j_a), 32'd194);
    chk("done_lat_b", 32'(done_j_b), 32'd162);
    chk("g_cnt_a", 32'(g_a), 32'd192);
    chk("g_cnt_b", 32'(g_b), 32'd160);
    chk("max_rnd_b", 32'(max_rnd_b), 32'd9);
    chk("fin_cnt_a", 32'(fin_a), 32'd1);
    chk("done_hold", 32'({dn_a, sr_a}), 32'({1'b1, 1'b0}));
    ack_v = 2'b11;
    tick();
    ack_v = 2'b00;
    chk("ack_idle", 32'({dn_a, sr_a}), 32'({1'b0, 1'b1}));

    // Abort at ROUND cycle 50
    start_v = 2'b01; last_v = 2'b01;
    tick();
    start_v = 2'b00; last_v = 2'b00;
    repeat (51) tick();
    abort_v = 2'b01;
    tick();
    abort_v = 2'b00;
    chk("abort_idle", 32'(obs_a), 32'h4000);
    repeat (5) tick();
    start_v = 2'b01;
    tick();
    start_v = 2'b00;
    chk("restart_a", 32'({iv_a, busy_a, ff_a}), 32'({1'b1, 1'b1, 1'b0}));

    // Asynchronous reset between edges, mid-ROUND
    start_v = 2'b10; last_v = 2'b10;
    tick();
    start_v = 2'b00; last_v = 2'b00;
    repeat (20) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", 32'(obs_a), 32'h4000);
    chk("async_rst_b", 32'(obs_b), 32'h4000);
    tick();
    tick();
    rst_n = 1'b1;
    start_v = 2'b11; last_v = 2'b00;
    tick();
    start_v = 2'b00;
    chk("b2b_flag_a", 32'({iv_a, ff_a}), 32'({1'b1, 1'b0}));
    chk("b2b_flag_b", 32'({iv_b, ff_b}), 32'({1'b1, 1'b0}));

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      start_v = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      last_v  = 2'($urandom_range(0, 3));
      abort_v = {($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0)};
      ack_v   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      tick();
    end
    start_v = 2'b00; abort_v = 2'b00; ack_v = 2'b00;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
